// File: rtl/spi_rx_pkg.sv
// Shared constants, FSM encoding and frame helpers for the SPI write-frame receiver.
package spi_rx_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    OVERRUN,
    COMMIT
  } state_e;

  localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'd4;

  function automatic logic frame_is_write(
    input logic [FRAME_BITS-1:0] f,
    input logic [ADDR_W-1:0]     amax
  );
    return f[FRAME_BITS-1] && (f[FRAME_BITS-2:DATA_W] <= amax);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop pin synchronizer with registered edge detection.
// Reset value is chosen per pin so an idle bus produces no edges.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 write-frame receiver; commits one register write per clean frame on nCS release.
// Define SPI_RX_ERR_CNT_EN to build the saturating frame-error counter.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_MAX    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_count
);

  logic sclk_level_unused, sclk_rise, sclk_fall_unused;
  logic copi_level, copi_rise_unused, copi_fall_unused;
  logic ncs_level, ncs_rise, ncs_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (copi),
    .level (copi_level),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ncs),
    .level (ncs_level),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_valid_d, frame_err_d;
  logic                  wr_valid_q, frame_err_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // ncs is checked before sclk in every state so a simultaneous
  // release and clock edge always ends the frame.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall || !ncs_level) begin
          state_d = SHIFT;
          shift_d = '0;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_level};
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(FRAME_BITS - 1))
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (ncs_rise)
          state_d = COMMIT;
        else if (sclk_rise)
          state_d = OVERRUN;
      end
      OVERRUN: begin
        if (ncs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      COMMIT: begin
        wr_valid_d = frame_is_write(shift_q, ADDR_W'(ADDR_MAX));
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      if (wr_valid_d) begin
        wr_addr_q <= shift_q[FRAME_BITS-2:DATA_W];
        wr_data_q <= shift_q[DATA_W-1:0];
      end
    end
  end

  assign wr_valid  = wr_valid_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != IDLE);

`ifdef SPI_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (frame_err_q && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
